blink_mode_ctrl: RTL

Upstream control stage for the LED blinker. It debounces two raw push-buttons, steps a 3-bit blink mode up or down with wrap-around, and drives the blinker's 16-bit `offset` (blink period) from the current mode. It sits between the `ui_in` pins and the blinker. Its mode register replaces the stand-alone state register in the top level.

---
 rtl/blink_mode_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/blink_mode_ctrl.sv
// blink_mode_ctrl: upstream control stage for the LED blinker.
// Synchronises and debounces two raw push-buttons, turns debounced presses
// into next/prev/reset-to-default mode steps with wrap-around, and drives the
// blinker period offset = BASE_OFFSET << mode.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   btn_next     - raw "next mode" button, active high, asynchronous
//   btn_prev     - raw "previous mode" button, active high, asynchronous
//   mode         - current blink mode (registered)
//   offset       - blink period for the blinker (registered)
//   mode_changed - one-cycle pulse in the cycle mode/offset take a new value
//   btn_db       - debounced levels {btn_prev, btn_next}
module blink_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned BASE_OFFSET     = 100,
    parameter logic [2:0]  DEFAULT_MODE    = 3'd5,
    parameter logic [2:0]  MAX_MODE        = 3'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [2:0]  mode,
    output logic [15:0] offset,
    output logic        mode_changed,
    output logic [1:0]  btn_db
);

    localparam int unsigned NB = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned MW = 3;
    localparam int unsigned OW = 16;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [OW-1:0] BASE_OFS   = OW'(BASE_OFFSET);
    localparam logic [OW-1:0] RST_OFFSET = BASE_OFS << DEFAULT_MODE;

    // Bit 0 = next, bit 1 = prev throughout.
    logic [NB-1:0] raw_btn;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] db_q;
    logic [NB-1:0] db_d;
    logic [NB-1:0] db_prev_q;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] press_ev;

    logic [MW-1:0] mode_q;
    logic [MW-1:0] mode_d;
    logic [OW-1:0] offset_q;
    logic [OW-1:0] offset_d;
    logic          changed_q;
    logic          changed_d;

    assign raw_btn = {btn_prev, btn_next};

    // Two-flop synchroniser, debounce state and the delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int b = 0; b < NB; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            sync1_q   <= raw_btn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int b = 0; b < NB; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Debounce: the level only follows s after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        db_d = db_q;
        for (int b = 0; b < NB; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != db_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
        end
    end

    // Rising edges only; releases are ignored.
    assign press_ev = db_q & ~db_prev_q;

    // Mode, offset and change-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= DEFAULT_MODE;
            offset_q  <= RST_OFFSET;
            changed_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            offset_q  <= offset_d;
            changed_q <= changed_d;
        end
    end

    // Next mode; a simultaneous press always reloads and always pulses.
    always_comb begin
        mode_d    = mode_q;
        changed_d = 1'b0;
        unique case (press_ev)
            2'b01: begin
                mode_d    = (mode_q == MAX_MODE) ? MW'(0) : mode_q + MW'(1);
                changed_d = 1'b1;
            end
            2'b10: begin
                mode_d    = (mode_q == MW'(0)) ? MAX_MODE : mode_q - MW'(1);
                changed_d = 1'b1;
            end
            2'b11: begin
                mode_d    = DEFAULT_MODE;
                changed_d = 1'b1;
            end
            default: begin
                mode_d    = mode_q;
                changed_d = 1'b0;
            end
        endcase
        offset_d = BASE_OFS << mode_d;
    end

    assign mode         = mode_q;
    assign offset       = offset_q;
    assign mode_changed = changed_q;
    assign btn_db       = db_q;

endmodule
